ysyx_22040237_mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the NPC core. It drives IFU fetch, the decode/execute datapath, the LSU and register-file writeback through an FSM.
- Owns the architectural PC plus the mcycle/minstret counters.
- Converts invalid instructions, ebreak, bus errors and bus timeouts into sticky halt/trap states that the simulation harness can observe.

---
 rtl/ysyx_22040237_mc_ctrl_pkg.sv | 26 ++
 rtl/ysyx_22040237_wdog.sv | 28 ++
 rtl/ysyx_22040237_mc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22040237_mc_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_mc_ctrl_pkg.sv
// Shared definitions for the ysyx_22040237 multi-cycle controller:
// FSM state encodings, trap cause codes and the default reset PC.
package ysyx_22040237_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    CTRL_FETCH  = 4'd0,
    CTRL_FWAIT  = 4'd1,
    CTRL_DECODE = 4'd2,
    CTRL_EXEC   = 4'd3,
    CTRL_MEM    = 4'd4,
    CTRL_MWAIT  = 4'd5,
    CTRL_WB     = 4'd6,
    CTRL_HALT   = 4'd7,
    CTRL_TRAP   = 4'd8
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TRAP_INVALID   = 2'd0,
    TRAP_FETCH_ERR = 2'd1,
    TRAP_LSU_ERR   = 2'd2,
    TRAP_TIMEOUT   = 2'd3
  } trap_cause_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040237_wdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th consecutive waiting cycle.
module ysyx_22040237_wdog #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the number of waiting cycles already completed, so the cycle
  // seeing TIMEOUT-1 is the TIMEOUT-th one.
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22040237_mc_ctrl.sv
// Multi-cycle sequencer for the NPC core: drives fetch, execute, LSU and
// writeback, owns PC/mcycle/minstret and parks in sticky HALT/TRAP states.
module ysyx_22040237_mc_ctrl
  import ysyx_22040237_mc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 1023,
  parameter int          CNT_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid_o,
  input  logic        ifu_req_ready_i,
  input  logic        ifu_resp_valid_i,
  input  logic        ifu_resp_err_i,
  output logic        ir_wr_en_o,
  output logic [63:0] pc_o,
  input  logic        dec_invalid_i,
  input  logic        dec_ebreak_i,
  input  logic        dec_load_i,
  input  logic        dec_store_i,
  input  logic        dec_rd_wr_en_i,
  input  logic        exu_multi_i,
  output logic        exu_start_o,
  input  logic        exu_done_i,
  input  logic [63:0] next_pc_i,
  output logic        lsu_req_valid_o,
  input  logic        lsu_req_ready_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  output logic        rf_wr_en_o,
  output logic        rf_wr_sel_o,
  output logic        commit_o,
  output logic        halt_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [63:0] mcycle_o,
  output logic [63:0] minstret_o
);

  ctrl_state_e state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic [63:0] pc_q, mcycle_q, minstret_q;
  logic        load_q, store_q, rd_wr_q, multi_q, exu_started_q;
  logic        latch_flags, pc_load, commit;
  logic        ifu_req, ir_wr, exu_start, lsu_req, rf_wr, rf_sel;
  logic        wd_en, wd_expired;

  assign wd_en = (state_q == CTRL_FWAIT) || (state_q == CTRL_MWAIT) ||
                 ((state_q == CTRL_EXEC) && multi_q);

  ysyx_22040237_wdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cause_d     = cause_q;
    latch_flags = 1'b0;
    pc_load     = 1'b0;
    commit      = 1'b0;
    ifu_req     = 1'b0;
    ir_wr       = 1'b0;
    exu_start   = 1'b0;
    lsu_req     = 1'b0;
    rf_wr       = 1'b0;
    rf_sel      = 1'b0;
    unique case (state_q)
      CTRL_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_req_ready_i) state_d = CTRL_FWAIT;
      end
      CTRL_FWAIT: begin
        if (ifu_resp_valid_i) begin
          if (ifu_resp_err_i) begin
            state_d = CTRL_TRAP;
            cause_d = TRAP_FETCH_ERR;
          end else begin
            ir_wr   = 1'b1;
            state_d = CTRL_DECODE;
          end
        end else if (wd_expired) begin
          state_d = CTRL_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      CTRL_DECODE: begin
        if (dec_invalid_i) begin
          state_d = CTRL_TRAP;
          cause_d = TRAP_INVALID;
        end else if (dec_ebreak_i) begin
          commit  = 1'b1;
          state_d = CTRL_HALT;
        end else begin
          latch_flags = 1'b1;
          state_d     = CTRL_EXEC;
        end
      end
      CTRL_EXEC: begin
        exu_start = !exu_started_q;
        if (!multi_q || exu_done_i) begin
          state_d = (load_q || store_q) ? CTRL_MEM : CTRL_WB;
        end else if (wd_expired) begin
          state_d = CTRL_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      CTRL_MEM: begin
        lsu_req = 1'b1;
        if (lsu_req_ready_i) state_d = CTRL_MWAIT;
      end
      CTRL_MWAIT: begin
        if (lsu_resp_valid_i) begin
          if (lsu_resp_err_i) begin
            state_d = CTRL_TRAP;
            cause_d = TRAP_LSU_ERR;
          end else begin
            state_d = CTRL_WB;
          end
        end else if (wd_expired) begin
          state_d = CTRL_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      CTRL_WB: begin
        rf_wr   = rd_wr_q && !store_q;
        rf_sel  = load_q;
        pc_load = 1'b1;
        commit  = 1'b1;
        state_d = CTRL_FETCH;
      end
      CTRL_HALT, CTRL_TRAP: state_d = state_q;
      default:              state_d = CTRL_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q       <= CTRL_FETCH;
      cause_q       <= TRAP_INVALID;
      pc_q          <= RESET_PC;
      mcycle_q      <= '0;
      minstret_q    <= '0;
      load_q        <= 1'b0;
      store_q       <= 1'b0;
      rd_wr_q       <= 1'b0;
      multi_q       <= 1'b0;
      exu_started_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      exu_started_q <= (state_q == CTRL_EXEC);
      if (latch_flags) begin
        load_q  <= dec_load_i;
        store_q <= dec_store_i;
        rd_wr_q <= dec_rd_wr_en_i;
        multi_q <= exu_multi_i;
      end
      if (pc_load) pc_q <= next_pc_i;
      if (state_q != CTRL_HALT && state_q != CTRL_TRAP) mcycle_q <= mcycle_q + 64'd1;
      if (commit) minstret_q <= minstret_q + 64'd1;
    end
  end

  // Reset is synchronous, so outputs are masked while it is held.
  assign ifu_req_valid_o = ifu_req && !rst;
  assign ir_wr_en_o      = ir_wr && !rst;
  assign exu_start_o     = exu_start && !rst;
  assign lsu_req_valid_o = lsu_req && !rst;
  assign rf_wr_en_o      = rf_wr && !rst;
  assign rf_wr_sel_o     = rf_sel && !rst;
  assign commit_o        = commit && !rst;
  assign halt_o          = (state_q == CTRL_HALT) && !rst;
  assign trap_o          = (state_q == CTRL_TRAP) && !rst;
  assign trap_cause_o    = ((state_q == CTRL_TRAP) && !rst) ? cause_q : 2'd0;
  assign pc_o            = pc_q;
  assign mcycle_o        = mcycle_q;
  assign minstret_o      = minstret_q;

endmodule

// File: tb/tb_ysyx_22040237_mc_ctrl.sv
// Self-checking bench for ysyx_22040237_mc_ctrl: builds per-instruction
// cycle timelines from phase durations and checks strobes and architectural state.
module tb_ysyx_22040237_mc_ctrl;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          TIMEOUT  = 1023;

  // stimulus bits: {ifu_rdy, ifu_rsp, ifu_err, exu_done, lsu_rdy, lsu_rsp, lsu_err}
  localparam logic [6:0] S_IRDY = 7'h40, S_IRSP = 7'h20, S_IERR = 7'h10, S_DONE = 7'h08;
  localparam logic [6:0] S_LRDY = 7'h04, S_LRSP = 7'h02, S_LERR = 7'h01;
  // observed bits: {ifu_req, ir_wr, exu_start, lsu_req, commit, rf_wr, rf_sel, halt, trap}
  localparam logic [8:0] E_IREQ = 9'h100, E_IRW = 9'h080, E_START = 9'h040, E_LREQ = 9'h020;
  localparam logic [8:0] E_COMMIT = 9'h010, E_RFWR = 9'h008, E_RFSEL = 9'h004;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ifu_req_valid_o, ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, ir_wr_en_o;
  logic [63:0] pc_o, next_pc_i, mcycle_o, minstret_o;
  logic        dec_invalid_i, dec_ebreak_i, dec_load_i, dec_store_i, dec_rd_wr_en_i, exu_multi_i;
  logic        exu_start_o, exu_done_i;
  logic        lsu_req_valid_o, lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i;
  logic        rf_wr_en_o, rf_wr_sel_o, commit_o, halt_o, trap_o;
  logic [1:0]  trap_cause_o;

  ysyx_22040237_mc_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
    .ifu_resp_valid_i(ifu_resp_valid_i), .ifu_resp_err_i(ifu_resp_err_i),
    .ir_wr_en_o(ir_wr_en_o), .pc_o(pc_o),
    .dec_invalid_i(dec_invalid_i), .dec_ebreak_i(dec_ebreak_i), .dec_load_i(dec_load_i),
    .dec_store_i(dec_store_i), .dec_rd_wr_en_i(dec_rd_wr_en_i), .exu_multi_i(exu_multi_i),
    .exu_start_o(exu_start_o), .exu_done_i(exu_done_i), .next_pc_i(next_pc_i),
    .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_sel_o(rf_wr_sel_o), .commit_o(commit_o),
    .halt_o(halt_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
    .mcycle_o(mcycle_o), .minstret_o(minstret_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [6:0] stim; logic [8:0] exp; } cyc_t;
  cyc_t        sched[$];
  int          vectors = 0, miscompares = 0;
  logic [63:0] pc_m, mcycle_m, minstret_m;

  function automatic logic [8:0] obs_vec();
    return {ifu_req_valid_o, ir_wr_en_o, exu_start_o, lsu_req_valid_o, commit_o,
            rf_wr_en_o, rf_wr_sel_o, halt_o, trap_o};
  endfunction

  function automatic void add(input logic [6:0] s, input logic [8:0] e);
    sched.push_back({s, e});
  endfunction

  function automatic void add_fetch(input int rdy, input int rsp, input logic err);
    for (int i = 0; i <= rdy; i++) add((i == rdy) ? S_IRDY : 7'h0, E_IREQ);
    for (int i = 0; i <= rsp; i++)
      if (i == rsp) add(S_IRSP | (err ? S_IERR : 7'h0), err ? 9'h0 : E_IRW);
      else          add(7'h0, 9'h0);
  endfunction

  function automatic void add_exec(input logic multi, input int dly);
    int n = multi ? dly + 1 : 1;
    for (int i = 0; i < n; i++) add((multi && i == dly) ? S_DONE : 7'h0, (i == 0) ? E_START : 9'h0);
  endfunction

  function automatic void add_mem(input int rdy, input int rsp, input logic err);
    for (int i = 0; i <= rdy; i++) add((i == rdy) ? S_LRDY : 7'h0, E_LREQ);
    for (int i = 0; i <= rsp; i++) add((i == rsp) ? (S_LRSP | (err ? S_LERR : 7'h0)) : 7'h0, 9'h0);
  endfunction

  function automatic void set_dec(input logic inv, ebr, ld, st, rd, multi);
    {dec_invalid_i, dec_ebreak_i, dec_load_i, dec_store_i, dec_rd_wr_en_i, exu_multi_i} =
      {inv, ebr, ld, st, rd, multi};
  endfunction

  // Applies the queued timeline one cycle per negedge and tallies deviating cycles.
  task automatic play(output int bad, output int at, output logic [8:0] got, output logic [8:0] want);
    cyc_t c;
    logic [8:0] o;
    int k = 0;
    bad = 0; at = -1; got = '0; want = '0;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
       lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = c.stim;
      #1;
      o = obs_vec();
      if (o !== c.exp) begin
        if (bad == 0) begin at = k; got = o; want = c.exp; end
        bad++;
      end
      mcycle_m++;
      k++;
      @(negedge clk);
    end
    {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
     lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = 7'h0;
  endtask

  // Random input noise while the DUT sits in a terminal state; returns OR of all strobes.
  task automatic idle(input int n, output logic [8:0] seen);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
       lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = 7'($urandom);
      #1;
      seen |= obs_vec();
      @(negedge clk);
    end
    {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
     lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = 7'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pc_m = RESET_PC; mcycle_m = '0; minstret_m = '0;
  endtask

  task automatic run_instr(input string tag, input int kind, input logic multi, input logic rd,
                           input int frdy, frsp, edly, lrdy, lrsp, input logic [63:0] npc);
    int bad, at;
    logic [8:0] got, want;
    logic ld, st;
    ld = (kind == 1); st = (kind == 2);
    set_dec(0, 0, ld, st, rd, multi);
    next_pc_i = npc;
    add_fetch(frdy, frsp, 1'b0);
    add(7'h0, 9'h0);
    add_exec(multi, edly);
    if (ld || st) add_mem(lrdy, lrsp, 1'b0);
    add(7'h0, E_COMMIT | ((rd && !st) ? E_RFWR : 9'h0) | (ld ? E_RFSEL : 9'h0));
    play(bad, at, got, want);
    pc_m = npc; minstret_m++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s timeline: %0d bad cycles, first at %0d got %b want %b", tag, bad, at, got, want);
    end
    vectors++;
    if (pc_o !== pc_m) begin miscompares++; $display("FAIL %s pc: got %h want %h", tag, pc_o, pc_m); end
    vectors++;
    if (minstret_o !== minstret_m) begin
      miscompares++; $display("FAIL %s minstret: got %0d want %0d", tag, minstret_o, minstret_m);
    end
    vectors++;
    if (mcycle_o !== mcycle_m) begin
      miscompares++; $display("FAIL %s mcycle: got %0d want %0d", tag, mcycle_o, mcycle_m);
    end
  endtask

  // Plays a timeline ending in HALT/TRAP, then checks the sticky terminal state.
  task automatic run_terminal(input string tag, input logic [2:0] want_flags);
    int bad, at;
    logic [8:0] got, want, seen;
    play(bad, at, got, want);
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s timeline: %0d bad cycles, first at %0d got %b want %b", tag, bad, at, got, want);
    end
    idle(6, seen);
    vectors++;
    if ({halt_o, trap_o, trap_cause_o} !== {want_flags[2], want_flags[2] ? 1'b0 : 1'b1, want_flags[1:0]}) begin
      miscompares++;
      $display("FAIL %s halt/trap/cause: got %b%b%0d want flags %b", tag, halt_o, trap_o, trap_cause_o, want_flags);
    end
    vectors++;
    if (seen[8:2] !== 7'h0) begin miscompares++; $display("FAIL %s terminal strobes: got %b want 0", tag, seen[8:2]); end
    vectors++;
    if ({pc_o, minstret_o, mcycle_o} !== {pc_m, minstret_m, mcycle_m}) begin
      miscompares++;
      $display("FAIL %s frozen state: pc %h minstret %0d mcycle %0d want %h %0d %0d",
               tag, pc_o, minstret_o, mcycle_o, pc_m, minstret_m, mcycle_m);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
       lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = 7'($urandom);
      set_dec(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
    end
    #1;
    vectors++;
    if ({obs_vec(), trap_cause_o} !== 11'h0) begin
      miscompares++; $display("FAIL reset outputs: got %b want 0", {obs_vec(), trap_cause_o});
    end
    vectors++;
    if ({pc_o, mcycle_o, minstret_o} !== {RESET_PC, 64'd0, 64'd0}) begin
      miscompares++; $display("FAIL reset regs: pc %h mcycle %0d minstret %0d", pc_o, mcycle_o, minstret_o);
    end
    {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
     lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = 7'h0;
    set_dec(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    vectors++;
    if (obs_vec() !== E_IREQ) begin miscompares++; $display("FAIL reset exit fetch: got %b want %b", obs_vec(), E_IREQ); end
    pc_m = RESET_PC; mcycle_m = '0; minstret_m = '0;
  endtask

  task automatic test_alu();
    run_instr("addi", 0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 64'h8000_0004);
  endtask

  task automatic test_load_store();
    run_instr("load", 1, 1'b0, 1'b1, 0, 0, 0, 3, 1, 64'h8000_0008);
    run_instr("store", 2, 1'b0, 1'b1, 0, 0, 0, 3, 1, 64'h8000_000c);
  endtask

  task automatic test_multi();
    run_instr("multi", 0, 1'b1, 1'b1, 1, 2, 6, 0, 0, 64'h8000_0100);
    run_instr("multi_done_first", 1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 64'h8000_0104);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_instr("random", int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {$urandom, $urandom & 32'hffff_fffc});
  endtask

  task automatic test_invalid_ebreak();
    apply_reset();
    run_instr("pre_invalid", 0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 64'h8000_0040);
    set_dec(1, 1, 0, 0, 1, 0);
    add_fetch(1, 1, 1'b0);
    add(7'h0, 9'h0);
    run_terminal("invalid", 3'b000);
  endtask

  task automatic test_ebreak();
    apply_reset();
    run_instr("pre_ebreak", 0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 64'h8000_0080);
    set_dec(0, 1, 0, 0, 0, 0);
    add_fetch(2, 0, 1'b0);
    add(7'h0, E_COMMIT);
    minstret_m++;
    run_terminal("ebreak", 3'b100);
    apply_reset();
    #1;
    vectors++;
    if ({pc_o, obs_vec()} !== {RESET_PC, E_IREQ}) begin
      miscompares++; $display("FAIL ebreak reset: pc %h outputs %b want %h %b", pc_o, obs_vec(), RESET_PC, E_IREQ);
    end
  endtask

  task automatic test_fetch_err();
    apply_reset();
    add_fetch(0, 2, 1'b1);
    run_terminal("fetch_err", 3'b001);
  endtask

  task automatic test_lsu_err();
    apply_reset();
    set_dec(0, 0, 1, 0, 1, 0);
    add_fetch(0, 0, 1'b0);
    add(7'h0, 9'h0);
    add_exec(1'b0, 0);
    add_mem(1, 2, 1'b1);
    run_terminal("lsu_err", 3'b010);
  endtask

  task automatic test_timeout();
    apply_reset();
    run_instr("resp_at_limit", 0, 1'b0, 1'b1, 0, TIMEOUT - 1, 0, 0, 0, 64'h8000_0200);
    run_instr("lsu_near_limit", 1, 1'b1, 1'b1, 0, 0, 40, 0, TIMEOUT - 1, 64'h8000_0204);
    set_dec(0, 0, 0, 0, 1, 0);
    add(S_IRDY, E_IREQ);
    for (int i = 0; i < TIMEOUT; i++) add(7'h0, 9'h0);
    run_terminal("fetch_timeout", 3'b011);
  endtask

  task automatic test_reset_mid_fwait();
    int bad, at;
    logic [8:0] got, want;
    apply_reset();
    run_instr("pre_mid", 0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 64'h8000_0300);
    add(S_IRDY, E_IREQ);
    add(7'h0, 9'h0);
    add(7'h0, 9'h0);
    play(bad, at, got, want);
    rst = 1'b1;
    ifu_resp_valid_i = 1'b1;
    #1;
    vectors++;
    if (obs_vec() !== 9'h0) begin miscompares++; $display("FAIL mid_rst outputs: got %b want 0", obs_vec()); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if ({pc_o, obs_vec()} !== {RESET_PC, E_IREQ}) begin
        miscompares++;
        $display("FAIL stale_resp cycle %0d: pc %h outputs %b want %h %b", i, pc_o, obs_vec(), RESET_PC, E_IREQ);
      end
      @(negedge clk);
    end
    ifu_resp_valid_i = 1'b0;
    apply_reset();
  endtask

  initial begin
    {ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i, exu_done_i,
     lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i} = 7'h0;
    set_dec(0, 0, 0, 0, 0, 0);
    next_pc_i = '0;
    test_reset();
    test_alu();
    test_load_store();
    test_multi();
    test_random();
    test_invalid_ebreak();
    test_ebreak();
    test_fetch_err();
    test_lsu_err();
    test_timeout();
    test_reset_mid_fwait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global time limit: simulation still running, required completion");
    $fatal(1, "time limit");
  end

endmodule
